// File: rtl/serial_mag_comparator_pkg.sv
// serial_mag_comparator_pkg: shared FSM state type and digit width for the serial comparator.
package serial_mag_comparator_pkg;
    localparam int DIGIT_W = 2;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/serial_mag_comparator_cmp2_slice.sv
// cmp2_slice: combinational one-hot gt/eq/lt compare of one 2-bit digit.
module cmp2_slice
    import serial_mag_comparator_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               gt,
    output logic               eq,
    output logic               lt
);
    assign gt = a > b;
    assign eq = a == b;
    assign lt = a < b;
endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first 2-bit-per-clock unsigned magnitude compare with valid/ready result.
// Define EARLY_EXIT_EN to finish as soon as the first unequal digit is seen.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic             d_gt, d_eq, d_lt;

    cmp2_slice u_slice (
        .a  (a_q[WIDTH-1 -: DIGIT_W]),
        .b  (b_q[WIDTH-1 -: DIGIT_W]),
        .gt (d_gt),
        .eq (d_eq),
        .lt (d_lt)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        if (flush) begin
            state_d   = IDLE;
            cnt_d     = '0;
            decided_d = 1'b0;
            gt_d      = 1'b0;
            eq_d      = 1'b0;
            lt_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d   = SCAN;
                    a_d       = a;
                    b_d       = b;
                    cnt_d     = CW'(N - 1);
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    eq_d      = 1'b0;
                    lt_d      = 1'b0;
                end
                SCAN: begin
                    // only the first unequal digit may set the result
                    if (!decided_q && !d_eq) begin
                        gt_d      = d_gt;
                        lt_d      = d_lt;
                        decided_d = 1'b1;
                    end
                    a_d   = a_q << DIGIT_W;
                    b_d   = b_q << DIGIT_W;
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        eq_d    = !decided_q && d_eq;
                    end
`ifdef EARLY_EXIT_EN
                    if (!decided_q && !d_eq) state_d = DONE;
`endif
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: directed and random checks of result and latency against an arithmetic model.
module tb_serial_mag_comparator;
    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, gt, eq, lt;
    int           checks = 0;
    int           passed = 0;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (x[i] != y[i]) return (W - 1 - i) / 2 + 2;
`endif
        return N + 1;
    endfunction

    function automatic int exp_res(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x > y) ? 4 : (x == y) ? 2 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a compare, wait for the result, check it, then optionally retire it.
    task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input bit retire);
        int cyc;
        chk({tag, " in_ready"}, int'(in_ready), 1);
        a = x; b = y; start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, cyc, exp_lat(x, y));
        chk({tag, " result"}, int'({gt, eq, lt}), exp_res(x, y));
        if (retire) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, " retired"}, int'({in_ready, out_valid}), 2);
            chk({tag, " held"}, int'({gt, eq, lt}), exp_res(x, y));
        end
    endtask

    initial begin
        #12;
        chk("reset outputs", int'({out_valid, gt, eq, lt}), 0);
        chk("reset in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run("t1 A5=A5", 8'hA5, 8'hA5, 1);
        run("t2 C0>40", 8'hC0, 8'h40, 1);
        run("t3 12<13", 8'h12, 8'h13, 1);

        // result held while consumer stalls; starts during DONE are ignored
        run("t4", 8'h3C, 8'h3B, 0);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            a = 8'h00; b = 8'hFF;
            tick();
            chk("t4 stall valid", int'({out_valid, in_ready}), 2);
            chk("t4 stall result", int'({gt, eq, lt}), 4);
        end
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("t4 back to idle", int'({in_ready, out_valid}), 2);
        tick();
        chk("t4 start ignored", int'(in_ready), 1);

        // flush before the early-exit configuration could finish
        a = 8'hFF; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
`ifndef EARLY_EXIT_EN
        tick();
`endif
        chk("t5 pre-flush valid", int'(out_valid), 0);
        flush = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0; start = 1'b0;
        chk("t5 flushed", int'({in_ready, out_valid, gt, eq, lt}), 16);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5 stays idle", int'({in_ready, out_valid, gt, eq, lt}), 16);
        end

        // async reset mid-scan, then back-to-back compares
        a = 8'h55; b = 8'h56; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6 reset immediate", int'({in_ready, out_valid, gt, eq, lt}), 16);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run("t6 01<02", 8'h01, 8'h02, 1);
        run("t6 b2b", 8'h80, 8'h80, 1);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom);
            y = (i % 4 == 0) ? x : W'($urandom);
            if (i % 5 == 1) y = x ^ W'(1 << $urandom_range(W - 1, 0));
            run("rand", x, y, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
